// File: rtl/axi_lite_stall_mem.sv
// AXI-Lite slave backed by a word memory, with a write-only console byte port
// and optional pseudo-random ready/response stalls driven by an xorshift generator.
module axi_lite_stall_mem #(
  parameter int unsigned MEM_WORDS    = 16384,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int unsigned STALL_EN     = 0,
  parameter logic [31:0] SEED         = 32'h2545_F491
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        err
);

  localparam int unsigned IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] lfsr, lfsr_t1, lfsr_t2, lfsr_nx;
  logic [4:0]  stall;
  logic        ar_full, aw_full, w_full;
  logic [31:0] ar_addr, aw_addr;
  wbeat_t      w_q;
  logic        rd_hit, wr_hit, wr_con, do_r, do_b;

  always_comb begin
    lfsr_t1 = lfsr ^ (lfsr << 13);
    lfsr_t2 = lfsr_t1 ^ (lfsr_t1 >> 17);
    lfsr_nx = lfsr_t2 ^ (lfsr_t2 << 5);
  end

  assign stall  = (STALL_EN != 0) ? lfsr[4:0] : 5'd0;
  assign rd_hit = ar_addr < MEM_BYTES;
  assign wr_hit = aw_addr < MEM_BYTES;
  assign wr_con = aw_addr == CONSOLE_ADDR;
  assign do_r   = ar_full & ~rvalid & ~stall[3];
  assign do_b   = aw_full & w_full & ~bvalid & ~stall[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr          <= SEED;
      arready       <= 1'b0;
      awready       <= 1'b0;
      wready        <= 1'b0;
      ar_full       <= 1'b0;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_addr       <= '0;
      aw_addr       <= '0;
      w_q           <= '0;
      rvalid        <= 1'b0;
      rdata         <= '0;
      rresp         <= 2'b00;
      bvalid        <= 1'b0;
      bresp         <= 2'b00;
      console_valid <= 1'b0;
      console_data  <= '0;
      err           <= 1'b0;
    end else begin
      lfsr          <= lfsr_nx;
      // Ready pulses for one cycle only, so a held valid never double-latches.
      arready       <= arvalid & ~ar_full & ~arready & ~stall[0];
      awready       <= awvalid & ~aw_full & ~awready & ~stall[1];
      wready        <= wvalid  & ~w_full  & ~wready  & ~stall[2];
      console_valid <= 1'b0;

      if (arvalid & arready) begin
        ar_full <= 1'b1;
        ar_addr <= araddr;
      end
      if (awvalid & awready) begin
        aw_full <= 1'b1;
        aw_addr <= awaddr;
      end
      if (wvalid & wready) begin
        w_full <= 1'b1;
        w_q    <= '{data: wdata, strb: wstrb};
      end

      if (do_r) begin
        ar_full <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_hit ? mem[ar_addr[IW+1:2]] : 32'd0;
        rresp   <= rd_hit ? 2'b00 : 2'b10;
        if (!rd_hit) err <= 1'b1;
      end else if (rvalid & rready) begin
        rvalid <= 1'b0;
      end

      if (do_b) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        if (wr_hit) begin
          bresp <= 2'b00;
        end else if (wr_con) begin
          bresp <= 2'b00;
          if (w_q.strb[0]) begin
            console_valid <= 1'b1;
            console_data  <= w_q.data[7:0];
          end
        end else begin
          bresp <= 2'b10;
          err   <= 1'b1;
        end
      end else if (bvalid & bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Memory has no reset so its contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (!reset && do_b && wr_hit) begin
      for (int k = 0; k < 4; k++)
        if (w_q.strb[k]) mem[aw_addr[IW+1:2]][k*8 +: 8] <= w_q.data[k*8 +: 8];
    end
  end

endmodule

// File: tb/tb_axi_lite_stall_mem.sv
// Bench: instance 0 (no stalls) takes directed timing/payload steps, instance 1
// (stalls on) takes a randomized run against a word-array model with mid-run resets.
module tb_axi_lite_stall_mem;
  localparam int unsigned MW  = 64;
  localparam logic [31:0] CON = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [3:0]  wstrb [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2], console_valid [2], err [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [7:0]  console_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_stall_mem #(.MEM_WORDS(MW), .CONSOLE_ADDR(CON), .STALL_EN(g)) u_dut (
      .clk(clk), .reset(reset[g]),
      .awvalid(awvalid[g]), .awready(awready[g]), .awaddr(awaddr[g]),
      .wvalid(wvalid[g]), .wready(wready[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
      .bvalid(bvalid[g]), .bready(bready[g]), .bresp(bresp[g]),
      .arvalid(arvalid[g]), .arready(arready[g]), .araddr(araddr[g]),
      .rvalid(rvalid[g]), .rready(rready[g]), .rdata(rdata[g]), .rresp(rresp[g]),
      .console_valid(console_valid[g]), .console_data(console_data[g]), .err(err[g]));
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         cons_cnt [2] = '{0, 0};
  logic [7:0] cons_last [2];
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (console_valid[d] === 1'b1) begin
        cons_cnt[d]++;
        cons_last[d] = console_data[d];
      end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("rst_awready", awready[d], 0);  chk("rst_wready", wready[d], 0);
    chk("rst_arready", arready[d], 0);  chk("rst_bvalid", bvalid[d], 0);
    chk("rst_rvalid", rvalid[d], 0);    chk("rst_cvalid", console_valid[d], 0);
    chk("rst_err", err[d], 0);          chk("rst_bresp", bresp[d], 0);
    chk("rst_rresp", rresp[d], 0);      chk("rst_rdata", rdata[d], 0);
    chk("rst_cdata", console_data[d], 0);
  endtask

  task automatic drop_inputs(input int d);
    awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 0; rready[d] = 0;
  endtask

  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int hold, output logic [1:0] resp, output int lat);
    int aw_st = 0, w_st = 0, t_aw = 0;
    bit aw_seen = 0, w_seen = 0, ok = 0;
    awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
    for (int n = 0; n < 300; n++) begin
      if (aw_st == 1) begin
        if (aw_seen) begin awvalid[d] = 0; aw_st = 2; end
        else if (awready[d]) aw_seen = 1;
      end
      if (w_st == 1) begin
        if (w_seen) begin wvalid[d] = 0; w_st = 2; end
        else if (wready[d]) w_seen = 1;
      end
      if (aw_st == 0 && n >= aw_dly) begin awvalid[d] = 1; aw_st = 1; t_aw = cyc; end
      if (w_st == 0 && n >= w_dly) begin wvalid[d] = 1; w_st = 1; end
      if (aw_st == 2 && w_st == 2) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("aw_w_handshake", ok, 1);
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      if (bvalid[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("b_timeout", ok, 1);
    lat = cyc - t_aw;
    resp = bresp[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid[d], 1);
      chk("bresp_hold", bresp[d], resp);
    end
    bready[d] = 1;
    @(negedge clk);
    bready[d] = 0;
    chk("bvalid_drop", bvalid[d], 0);
  endtask

  task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t0;
    bit seen = 0, ok = 0;
    araddr[d] = addr; arvalid[d] = 1; t0 = cyc;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (seen) begin arvalid[d] = 0; ok = 1; break; end
      if (arready[d]) seen = 1;
    end
    chk("ar_handshake", ok, 1);
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      if (rvalid[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("r_timeout", ok, 1);
    lat = cyc - t0;
    data = rdata[d]; resp = rresp[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid[d], 1);
      chk("rdata_hold", rdata[d], data);
      chk("rresp_hold", rresp[d], resp);
    end
    rready[d] = 1;
    @(negedge clk);
    rready[d] = 0;
    chk("rvalid_drop", rvalid[d], 0);
  endtask

  logic [31:0] m [MW];
  bit          exp_err;
  int          exp_cons;

  // Reset instance 1 with a transaction in flight; a write in flight carries the
  // model's current word so memory is the same whether or not it committed.
  task automatic mid_reset(input bit is_write);
    int idx = $urandom_range(0, MW - 1);
    logic [31:0] d32; logic [1:0] r2; int lat;
    if (is_write) begin
      awaddr[1] = idx * 4; wdata[1] = m[idx]; wstrb[1] = 4'hF;
      awvalid[1] = 1; wvalid[1] = 1;
    end else begin
      araddr[1] = idx * 4; arvalid[1] = 1;
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    reset[1] = 1;
    drop_inputs(1);
    repeat (2) @(negedge clk);
    chk_zero(1);
    reset[1] = 0;
    exp_err = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_bvalid", bvalid[1], 0);
    chk("post_rst_rvalid", rvalid[1], 0);
    for (int i = 0; i < MW; i++) begin
      do_read(1, i * 4, 0, d32, r2, lat);
      chk("preserve_data", d32, m[i]);
    end
  endtask

  initial begin
    logic [31:0] d32, a, v, x;
    logic [1:0]  r2;
    logic [3:0]  s4;
    int          lat, c0, r, idx;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1; drop_inputs(d);
      awaddr[d] = 0; wdata[d] = 0; wstrb[d] = 0; araddr[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    reset[0] = 0; reset[1] = 0;
    @(negedge clk);

    // Full-word write then read; valid is first sampled on one edge, response two edges later.
    do_write(0, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r2, lat);
    chk("wr40_bresp", r2, 2'b00);
    chk("wr40_lat", lat, 3);
    do_read(0, 32'h40, 0, d32, r2, lat);
    chk("rd40_data", d32, 32'hDEAD_BEEF);
    chk("rd40_rresp", r2, 2'b00);
    chk("rd40_lat", lat, 3);

    // Partial strobes merge into an existing word; low address bits are ignored.
    do_write(0, 32'h80, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r2, lat);
    do_write(0, 32'h80, 32'h1122_3344, 4'b0101, 0, 0, 0, r2, lat);
    chk("wr80_bresp", r2, 2'b00);
    do_read(0, 32'h80, 0, d32, r2, lat);
    chk("rd80_merge", d32, 32'hFF22_FF44);
    do_read(0, 32'h83, 0, d32, r2, lat);
    chk("rd83_lowbits", d32, 32'hFF22_FF44);

    // Console byte.
    c0 = cons_cnt[0];
    do_write(0, CON, 32'h0000_0041, 4'hF, 0, 0, 0, r2, lat);
    repeat (2) @(negedge clk);
    chk("con_bresp", r2, 2'b00);
    chk("con_count", cons_cnt[0] - c0, 1);
    chk("con_data", cons_last[0], 8'h41);
    chk("con_err", err[0], 0);
    c0 = cons_cnt[0];
    do_write(0, CON, 32'h0000_0055, 4'b1110, 0, 0, 0, r2, lat);
    repeat (2) @(negedge clk);
    chk("con_nostrb_count", cons_cnt[0] - c0, 0);
    chk("con_nostrb_bresp", r2, 2'b00);

    // Out-of-range just past the end must not alias onto word 0.
    do_write(0, 32'h0, 32'hA5A5_0001, 4'hF, 0, 0, 0, r2, lat);
    do_read(0, MW * 4, 0, d32, r2, lat);
    chk("oor_rd_data", d32, 0);
    chk("oor_rd_rresp", r2, 2'b10);
    chk("oor_rd_err", err[0], 1);
    do_write(0, MW * 4, 32'h1234_5678, 4'hF, 0, 0, 0, r2, lat);
    chk("oor_wr_bresp", r2, 2'b10);
    do_read(0, 32'h0, 0, d32, r2, lat);
    chk("oor_mem_unchanged", d32, 32'hA5A5_0001);
    do_read(0, 32'h8000_0040, 0, d32, r2, lat);
    chk("oor_high_rresp", r2, 2'b10);
    do_read(0, CON, 0, d32, r2, lat);
    chk("con_rd_rresp", r2, 2'b10);
    chk("con_rd_data", d32, 0);
    chk("err_sticky", err[0], 1);

    // W leads AW by two cycles; both responses held back for five cycles.
    do_write(0, 32'hC0, 32'hCAFE_F00D, 4'hF, 2, 0, 5, r2, lat);
    chk("wfirst_bresp", r2, 2'b00);
    chk("wfirst_lat", lat, 3);
    repeat (3) @(negedge clk);
    chk("single_b", bvalid[0], 0);
    do_read(0, 32'hC0, 5, d32, r2, lat);
    chk("wfirst_data", d32, 32'hCAFE_F00D);

    // Reset clears err but keeps memory.
    reset[0] = 1;
    repeat (2) @(negedge clk);
    chk_zero(0);
    reset[0] = 0;
    @(negedge clk);
    do_read(0, 32'h40, 0, d32, r2, lat);
    chk("rst_preserve", d32, 32'hDEAD_BEEF);

    // Randomized run on the stalling instance.
    exp_err = 0;
    exp_cons = cons_cnt[1];
    for (int i = 0; i < MW; i++) begin
      v = $urandom;
      do_write(1, i * 4, v, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), r2, lat);
      chk("prefill_bresp", r2, 2'b00);
      m[i] = v;
    end
    for (int op = 0; op < 1000; op++) begin
      if (op == 400) mid_reset(0);
      if (op == 700) mid_reset(1);
      r = $urandom_range(0, 99);
      if (r < 80)      a = $urandom_range(0, MW * 4 - 1);
      else if (r < 88) a = CON;
      else if (r < 94) a = MW * 4 + $urandom_range(0, 255) * 4;
      else             a = $urandom | 32'h100;
      if ($urandom_range(0, 1) == 0) begin
        do_read(1, a, $urandom_range(0, 3), d32, r2, lat);
        if (a < MW * 4) begin
          chk("rnd_rdata", d32, m[a >> 2]);
          chk("rnd_rresp", r2, 2'b00);
        end else begin
          chk("rnd_oor_rdata", d32, 0);
          chk("rnd_oor_rresp", r2, 2'b10);
          exp_err = 1;
        end
      end else begin
        x = $urandom;
        s4 = 4'($urandom_range(0, 15));
        do_write(1, a, x, s4, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r2, lat);
        if (a < MW * 4) begin
          idx = a >> 2;
          for (int k = 0; k < 4; k++) if (s4[k]) m[idx][k*8 +: 8] = x[k*8 +: 8];
          chk("rnd_bresp", r2, 2'b00);
        end else if (a == CON) begin
          chk("rnd_con_bresp", r2, 2'b00);
          if (s4[0]) exp_cons++;
        end else begin
          chk("rnd_oor_bresp", r2, 2'b10);
          exp_err = 1;
        end
      end
      chk("rnd_err", err[1], exp_err);
    end
    repeat (2) @(negedge clk);
    chk("rnd_console_count", cons_cnt[1], exp_cons);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
